cpu_sram_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SRAM-like request/response bus between the CPU core and memory. It multiplexes the fetch port (inst) and the load/store port (data) onto a single downstream port, with one outstanding transaction at a time. It registers each accepted request, drives it downstream until the slave accepts it, and routes the response back to its owner. Round-robin on conflict; data wins the first conflict after reset.

---
 rtl/cpu_sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_arbiter.sv
// Two-master (fetch/load-store) to one-slave SRAM-like bus arbiter.
// One outstanding transaction; round-robin on conflict, data first after reset.
module cpu_sram_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 1 = data
  logic        owner_q, owner_d;            // 1 = data
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        grant_inst, grant_data;

  // Grant is gated by resetn so addr_ok is low while reset is asserted.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn && state_q == IDLE) begin
      grant_data = data_req && (!inst_req || !last_grant_q);
      grant_inst = inst_req && !grant_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_size_d   = mem_size_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_inst || grant_data) begin
          owner_d      = grant_data;
          last_grant_d = grant_data;
          mem_req_d    = 1'b1;
          mem_wr_d     = grant_data ? data_wr    : inst_wr;
          mem_size_d   = grant_data ? data_size  : inst_size;
          mem_wstrb_d  = grant_data ? data_wstrb : inst_wstrb;
          mem_addr_d   = grant_data ? data_addr  : inst_addr;
          mem_wdata_d  = grant_data ? data_wdata : inst_wdata;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (mem_data_ok) begin
            if (owner_q) data_rdata_d = mem_rdata;
            else         inst_rdata_d = mem_rdata;
            state_d = DONE;
          end
        end
      end
      RESP: begin
        if (mem_data_ok) begin
          if (owner_q) data_rdata_d = mem_rdata;
          else         inst_rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_size_q   <= mem_size_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = (state_q == DONE) && !owner_q;
  assign data_data_ok = (state_q == DONE) && owner_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_wr       = mem_wr_q;
  assign mem_size     = mem_size_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed self-checking bench for cpu_sram_arbiter; inputs are driven and
// outputs sampled shortly after each rising edge.
module tb_cpu_sram_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  cpu_sram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1;
    step();
    settle();
    total_cnt++; if (inst_addr_ok !== 1'b0) $display("FAIL rst_inst_aok got=%0h exp=0", inst_addr_ok); else pass_cnt++;
    total_cnt++; if (data_addr_ok !== 1'b0) $display("FAIL rst_data_aok got=%0h exp=0", data_addr_ok); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0h exp=0", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if ({inst_data_ok, data_data_ok} !== 2'b00) $display("FAIL rst_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); else pass_cnt++;
    total_cnt++; if ({inst_rdata, data_rdata} !== 64'h0) $display("FAIL rst_rdata got=%h exp=0", {inst_rdata, data_rdata}); else pass_cnt++;
    idle_inputs();
    step();
    resetn = 1;
    step();
  endtask

  task automatic test_single_inst_read();
    inst_req = 1; inst_addr = 32'h1C000000; inst_size = 2;
    settle();
    total_cnt++; if (inst_addr_ok !== 1'b1) $display("FAIL sir_inst_aok got=%0h exp=1", inst_addr_ok); else pass_cnt++;
    total_cnt++; if (data_addr_ok !== 1'b0) $display("FAIL sir_data_aok got=%0h exp=0", data_addr_ok); else pass_cnt++;
    step(); // T+1
    inst_req = 0; inst_addr = 32'hFFFFFFFF; mem_addr_ok = 1;
    settle();
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL sir_mem_req_t1 got=%0h exp=1", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h1C000000) $display("FAIL sir_mem_addr got=%h exp=1c000000", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wr !== 1'b0) $display("FAIL sir_mem_wr got=%0h exp=0", mem_wr); else pass_cnt++;
    step(); // T+2
    mem_addr_ok = 0;
    settle();
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL sir_mem_req_t2 got=%0h exp=0", mem_req); else pass_cnt++;
    step(); // T+3
    mem_data_ok = 1; mem_rdata = 32'h02800C0C;
    settle();
    total_cnt++; if (inst_data_ok !== 1'b0) $display("FAIL sir_early_dok got=%0h exp=0", inst_data_ok); else pass_cnt++;
    step(); // T+4
    mem_data_ok = 0; mem_rdata = 32'h0;
    settle();
    total_cnt++; if (inst_data_ok !== 1'b1) $display("FAIL sir_inst_dok got=%0h exp=1", inst_data_ok); else pass_cnt++;
    total_cnt++; if (inst_rdata !== 32'h02800C0C) $display("FAIL sir_inst_rdata got=%h exp=02800c0c", inst_rdata); else pass_cnt++;
    total_cnt++; if (data_data_ok !== 1'b0) $display("FAIL sir_data_dok got=%0h exp=0", data_data_ok); else pass_cnt++;
    step(); // T+5
    total_cnt++; if (inst_data_ok !== 1'b0) $display("FAIL sir_dok_pulse got=%0h exp=0", inst_data_ok); else pass_cnt++;
    total_cnt++; if (inst_rdata !== 32'h02800C0C) $display("FAIL sir_rdata_hold got=%h exp=02800c0c", inst_rdata); else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic        exp_data;
    logic [31:0] exp_addr;
    inst_req = 1; inst_addr = 32'h00000100;
    data_req = 1; data_addr = 32'h00000200;
    for (int k = 0; k < 3; k++) begin
      exp_data = (k % 2 == 0);
      exp_addr = exp_data ? 32'h00000200 : 32'h00000100;
      settle();
      total_cnt++; if (data_addr_ok !== exp_data) $display("FAIL cf%0d_data_aok got=%0h exp=%0h", k, data_addr_ok, exp_data); else pass_cnt++;
      total_cnt++; if (inst_addr_ok !== !exp_data) $display("FAIL cf%0d_inst_aok got=%0h exp=%0h", k, inst_addr_ok, !exp_data); else pass_cnt++;
      step(); // REQ: accept and respond in the same cycle
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h10000000 + k;
      settle();
      total_cnt++; if (mem_addr !== exp_addr) $display("FAIL cf%0d_mem_addr got=%h exp=%h", k, mem_addr, exp_addr); else pass_cnt++;
      total_cnt++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) $display("FAIL cf%0d_aok_busy got=%b exp=00", k, {inst_addr_ok, data_addr_ok}); else pass_cnt++;
      step(); // DONE
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      settle();
      total_cnt++; if (data_data_ok !== exp_data) $display("FAIL cf%0d_data_dok got=%0h exp=%0h", k, data_data_ok, exp_data); else pass_cnt++;
      total_cnt++; if (inst_data_ok !== !exp_data) $display("FAIL cf%0d_inst_dok got=%0h exp=%0h", k, inst_data_ok, !exp_data); else pass_cnt++;
      total_cnt++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) $display("FAIL cf%0d_aok_done got=%b exp=00", k, {inst_addr_ok, data_addr_ok}); else pass_cnt++;
      step(); // IDLE
    end
    total_cnt++; if (data_rdata !== 32'h10000002) $display("FAIL cf_data_rdata got=%h exp=10000002", data_rdata); else pass_cnt++;
    total_cnt++; if (inst_rdata !== 32'h10000001) $display("FAIL cf_inst_rdata got=%h exp=10000001", inst_rdata); else pass_cnt++;
    inst_req = 0; data_req = 0;
    settle();
  endtask

  task automatic test_data_write();
    data_req = 1; data_wr = 1; data_size = 1; data_wstrb = 4'b0011;
    data_addr = 32'h1C0800F0; data_wdata = 32'hDEADBEEF;
    settle();
    total_cnt++; if (data_addr_ok !== 1'b1) $display("FAIL dw_aok got=%0h exp=1", data_addr_ok); else pass_cnt++;
    step();
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    for (int c = 0; c < 2; c++) begin
      mem_addr_ok = (c == 1);
      settle();
      total_cnt++; if (mem_req !== 1'b1) $display("FAIL dw%0d_mem_req got=%0h exp=1", c, mem_req); else pass_cnt++;
      total_cnt++; if ({mem_wr, mem_size, mem_wstrb} !== {1'b1, 2'd1, 4'b0011}) $display("FAIL dw%0d_ctl got=%b exp=1010011", c, {mem_wr, mem_size, mem_wstrb}); else pass_cnt++;
      total_cnt++; if (mem_addr !== 32'h1C0800F0) $display("FAIL dw%0d_addr got=%h exp=1c0800f0", c, mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL dw%0d_wdata got=%h exp=deadbeef", c, mem_wdata); else pass_cnt++;
      step();
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
    step();
    mem_data_ok = 0; mem_rdata = 0;
    settle();
    total_cnt++; if (data_data_ok !== 1'b1) $display("FAIL dw_dok got=%0h exp=1", data_data_ok); else pass_cnt++;
    total_cnt++; if (data_rdata !== 32'h12345678) $display("FAIL dw_rdata got=%h exp=12345678", data_rdata); else pass_cnt++;
    step();
    total_cnt++; if (data_data_ok !== 1'b0) $display("FAIL dw_dok_pulse got=%0h exp=0", data_data_ok); else pass_cnt++;
  endtask

  task automatic test_slave_stall();
    inst_req = 1; inst_addr = 32'h1C000040; inst_size = 2;
    settle();
    total_cnt++; if (inst_addr_ok !== 1'b1) $display("FAIL st_aok got=%0h exp=1", inst_addr_ok); else pass_cnt++;
    step();
    inst_addr = 32'h0; data_req = 1; data_addr = 32'h0000BEEF;
    for (int c = 0; c < 5; c++) begin
      settle();
      total_cnt++; if (mem_req !== 1'b1) $display("FAIL st%0d_mem_req got=%0h exp=1", c, mem_req); else pass_cnt++;
      total_cnt++; if (mem_addr !== 32'h1C000040) $display("FAIL st%0d_addr got=%h exp=1c000040", c, mem_addr); else pass_cnt++;
      total_cnt++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) $display("FAIL st%0d_aok got=%b exp=00", c, {inst_addr_ok, data_addr_ok}); else pass_cnt++;
      step();
    end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
    settle();
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL st_mem_req_drop got=%0h exp=0", mem_req); else pass_cnt++;
    step();
    mem_data_ok = 0; inst_req = 0; data_req = 0;
    settle();
    total_cnt++; if (inst_data_ok !== 1'b1) $display("FAIL st_inst_dok got=%0h exp=1", inst_data_ok); else pass_cnt++;
    total_cnt++; if (inst_rdata !== 32'hCAFEF00D) $display("FAIL st_inst_rdata got=%h exp=cafef00d", inst_rdata); else pass_cnt++;
    step();
  endtask

  task automatic test_same_cycle();
    data_req = 1; data_addr = 32'h00000300;
    settle();
    total_cnt++; if (data_addr_ok !== 1'b1) $display("FAIL sc_aok got=%0h exp=1", data_addr_ok); else pass_cnt++;
    step();
    data_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hA5A55A5A;
    step();
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    settle();
    total_cnt++; if (data_data_ok !== 1'b1) $display("FAIL sc_dok got=%0h exp=1", data_data_ok); else pass_cnt++;
    total_cnt++; if (data_rdata !== 32'hA5A55A5A) $display("FAIL sc_rdata got=%h exp=a5a55a5a", data_rdata); else pass_cnt++;
    step();
    total_cnt++; if (data_data_ok !== 1'b0) $display("FAIL sc_dok_pulse got=%0h exp=0", data_data_ok); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'h00000400;
    settle();
    step(); // REQ
    inst_req = 0; mem_addr_ok = 1;
    step(); // RESP
    mem_addr_ok = 0;
    settle();
    resetn = 0; inst_req = 1; data_req = 1;
    settle();
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL rm_mem_req got=%0h exp=0", mem_req); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL rm_mem_addr got=%h exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) $display("FAIL rm_aok got=%b exp=00", {inst_addr_ok, data_addr_ok}); else pass_cnt++;
    total_cnt++; if ({inst_rdata, data_rdata} !== 64'h0) $display("FAIL rm_rdata got=%h exp=0", {inst_rdata, data_rdata}); else pass_cnt++;
    step();
    inst_req = 0; data_req = 0;
    resetn = 1;
    mem_data_ok = 1; mem_rdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_data_ok = 0;
      settle();
      total_cnt++; if ({inst_data_ok, data_data_ok} !== 2'b00) $display("FAIL rm%0d_dok got=%b exp=00", c, {inst_data_ok, data_data_ok}); else pass_cnt++;
    end
    inst_req = 1; data_req = 1;
    settle();
    total_cnt++; if (data_addr_ok !== 1'b1) $display("FAIL rm_conf_data got=%0h exp=1", data_addr_ok); else pass_cnt++;
    total_cnt++; if (inst_addr_ok !== 1'b0) $display("FAIL rm_conf_inst got=%0h exp=0", inst_addr_ok); else pass_cnt++;
    step();
    inst_req = 0; data_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_inst_read();
    test_reset();
    test_conflict();
    test_data_write();
    test_slave_stall();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
